// File: rtl/noise_pkg.sv
// noise_pkg: shared types, default constants and helper functions for the
// noise conditioner (pair-FSM state enum, LFSR defaults, Galois step).
package noise_pkg;

  typedef enum logic {
    EMPTY,
    HAVE_FIRST
  } pair_state_t;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

  // Width of a counter that must be able to hold the value 'limit'.
  function automatic int rep_cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

  // One Galois step on a zero-extended state: shift right, apply taps when
  // the bit shifted out is 1, optionally flip the top bit with entropy, and
  // fall back to the seed if the result would be the all-zero lock-up state.
  function automatic logic [31:0] lfsr_advance(input logic [31:0] cur,
                                               input logic [31:0] taps,
                                               input logic [31:0] seed,
                                               input logic [4:0]  msb,
                                               input logic        mix);
    logic [31:0] nxt;
    nxt = (cur >> 1) ^ (cur[0] ? taps : 32'd0);
    nxt[msb] = nxt[msb] ^ mix;
    if (nxt == 32'd0) begin
      nxt = seed;
    end
    return nxt;
  endfunction

  // Bit 0 of the next state, used to load the output register on the same
  // edge the LFSR advances.
  function automatic logic lfsr_next_lsb(input logic [31:0] cur,
                                         input logic [31:0] taps,
                                         input logic [31:0] seed,
                                         input logic [4:0]  msb,
                                         input logic        mix);
    logic [31:0] nxt;
    nxt = lfsr_advance(cur, taps, seed, msb, mix);
    return nxt[0];
  endfunction

endpackage

// File: rtl/noise_lfsr.sv
// noise_lfsr: Galois LFSR with single-bit entropy XOR into the top bit and a
// zero-state guard that reloads the seed.
module noise_lfsr
  import noise_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS,
  parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load_seed,
  input  logic             mix_bit,
  input  logic             mix_valid,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] next_state;

  // Next state: shift, taps, optional entropy flip, lock-up guard.
  always_comb begin
    next_state = WIDTH'(lfsr_advance(32'(state), 32'(TAPS), 32'(SEED),
                                     5'(WIDTH - 1), mix_bit & mix_valid));
  end

  // State register: seed reload wins over an ordinary step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (load_seed) begin
      state <= SEED;
    end else if (step) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/noise_conditioner.sv
// noise_conditioner: synchronises a raw noise pin, debiases it, stirs it into
// an LFSR and hands out one conditioned bit per valid/ready transfer, with a
// repetition-count health test for a stuck source.
// Build option: define VN_DEBIAS_EN to enable the von Neumann pair debiaser;
// without it every sampled raw bit is mixed directly.
module noise_conditioner
  import noise_pkg::*;
#(
  parameter int                    LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = DEFAULT_TAPS,
  parameter logic [LFSR_WIDTH-1:0] SEED       = DEFAULT_SEED,
  parameter int                    REP_LIMIT  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw_noise,
  input  logic reseed,
  output logic noise_bit,
  output logic noise_valid,
  input  logic noise_ready,
  output logic health_fail
);

  localparam int CW = rep_cnt_width(REP_LIMIT);

  logic [1:0]            sync_q;
  logic                  raw_s;
  logic                  step;
  logic                  vn_bit;
  logic                  vn_valid;
  logic                  mix_valid;
  logic                  next_bit;
  logic [LFSR_WIDTH-1:0] lfsr_state;
  logic [CW-1:0]         rep_cnt;
  logic [CW-1:0]         rep_next;
  logic                  last_raw;

  assign raw_s     = sync_q[1];
  assign step      = en & ~reseed;
  assign mix_valid = vn_valid & ~health_fail;

  // Two-flop synchroniser for the asynchronous noise pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw_noise};
    end
  end

`ifdef VN_DEBIAS_EN
  pair_state_t pair_state;
  pair_state_t pair_next;
  logic        first_bit;
  logic        first_next;

  // Pair FSM register; reseed discards any half-collected pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_state <= EMPTY;
      first_bit  <= 1'b0;
    end else if (reseed) begin
      pair_state <= EMPTY;
    end else begin
      pair_state <= pair_next;
      first_bit  <= first_next;
    end
  end

  // Von Neumann pairing: 01 gives 0, 10 gives 1, equal pairs are dropped.
  always_comb begin
    pair_next  = pair_state;
    first_next = first_bit;
    vn_bit     = first_bit;
    vn_valid   = 1'b0;
    if (step) begin
      case (pair_state)
        EMPTY: begin
          first_next = raw_s;
          pair_next  = HAVE_FIRST;
        end
        HAVE_FIRST: begin
          vn_valid  = (first_bit != raw_s);
          pair_next = EMPTY;
        end
        default: pair_next = EMPTY;
      endcase
    end
  end
`else
  assign vn_bit   = raw_s;
  assign vn_valid = step;
`endif

  noise_lfsr #(
    .WIDTH(LFSR_WIDTH),
    .TAPS (LFSR_TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .step     (step),
    .load_seed(reseed),
    .mix_bit  (vn_bit),
    .mix_valid(mix_valid),
    .state    (lfsr_state)
  );

  // Lowest bit of the state the LFSR moves to on this edge.
  always_comb begin
    next_bit = lfsr_next_lsb(32'(lfsr_state), 32'(LFSR_TAPS), 32'(SEED),
                             5'(LFSR_WIDTH - 1), vn_bit & mix_valid);
  end

  // Output register: reload on a step when empty or being consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      noise_bit   <= 1'b0;
      noise_valid <= 1'b0;
    end else if (reseed) begin
      noise_valid <= 1'b0;
    end else if (step && (!noise_valid || noise_ready)) begin
      noise_bit   <= next_bit;
      noise_valid <= 1'b1;
    end else if (noise_ready) begin
      noise_valid <= 1'b0;
    end
  end

  // Saturating run length of identical raw samples.
  always_comb begin
    if (raw_s == last_raw) begin
      rep_next = (rep_cnt == '1) ? rep_cnt : rep_cnt + 1'b1;
    end else begin
      rep_next = CW'(1);
    end
  end

  // Repetition-count health test with a sticky failure flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt     <= '0;
      last_raw    <= 1'b0;
      health_fail <= 1'b0;
    end else if (reseed) begin
      rep_cnt     <= '0;
      health_fail <= 1'b0;
    end else if (step) begin
      rep_cnt  <= rep_next;
      last_raw <= raw_s;
      if (rep_next == CW'(REP_LIMIT)) begin
        health_fail <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noise_conditioner.sv
// tb_noise_conditioner: directed self-checking bench for noise_conditioner.
// Works in both builds (with or without VN_DEBIAS_EN).
module tb_noise_conditioner;
  import noise_pkg::*;

`ifdef VN_DEBIAS_EN
  localparam logic [15:0] GUARD_SEED = 16'hD002;
`else
  localparam logic [15:0] GUARD_SEED = 16'h6801;
`endif

  logic clk = 1'b0;
  logic rst, en, raw_noise, reseed, noise_ready;
  logic noise_bit, noise_valid, health_fail;
  logic g_en, g_raw, g_reseed, g_ready;
  logic g_bit, g_valid, g_fail;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [15:0] model;
  logic        have_first;
  logic        first_raw;
  logic        mix;

  always #5 clk = ~clk;

  noise_conditioner dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .raw_noise  (raw_noise),
    .reseed     (reseed),
    .noise_bit  (noise_bit),
    .noise_valid(noise_valid),
    .noise_ready(noise_ready),
    .health_fail(health_fail)
  );

  noise_conditioner #(.SEED(GUARD_SEED)) dut_guard (
    .clk        (clk),
    .rst        (rst),
    .en         (g_en),
    .raw_noise  (g_raw),
    .reseed     (g_reseed),
    .noise_bit  (g_bit),
    .noise_valid(g_valid),
    .noise_ready(g_ready),
    .health_fail(g_fail)
  );

  // Reference Galois step for the 16-bit default configuration.
  function automatic logic [15:0] model_next(input logic [15:0] s, input logic m);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) n = n ^ 16'hB400;
    n[15] = n[15] ^ m;
    if (n == 16'h0000) n = 16'hACE1;
    return n;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic e);
    en = e;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic guard_cycle(input logic e);
    g_en = e;
    @(posedge clk);
    #1;
    g_en = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; raw_noise = 1'b0; reseed = 1'b0; noise_ready = 1'b1;
    g_en = 1'b0; g_raw = 1'b0; g_reseed = 1'b0; g_ready = 1'b1;
    #12;
    check_output("reset_bit",    32'(noise_bit),   32'd0);
    check_output("reset_valid",  32'(noise_valid), 32'd0);
    check_output("reset_health", 32'(health_fail), 32'd0);
    check_output("reset_lfsr",   32'(dut.u_lfsr.state), 32'hACE1);
    rst = 1'b0;

    // Constant-zero source: pure LFSR sequence, health trips at 32 repeats.
    model = 16'hACE1;
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1'b1);
      model = model_next(model, 1'b0);
      if (i == 0) begin
        check_output("first_lfsr",  32'(dut.u_lfsr.state), 32'hE270);
        check_output("first_bit",   32'(noise_bit),   32'd0);
        check_output("first_valid", 32'(noise_valid), 32'd1);
      end
      if (i == 4) check_output("s5_bit", 32'(noise_bit), 32'd1);
      check_output("stuck_lfsr",   32'(dut.u_lfsr.state), 32'(model));
      check_output("stuck_bit",    32'(noise_bit), 32'(model[0]));
      check_output("stuck_health", 32'(health_fail), (i == 31) ? 32'd1 : 32'd0);
      apply_stimulus(1'b0);
    end

    // Failed state keeps producing output; reseed with en clears it.
    apply_stimulus(1'b1);
    model = model_next(model, 1'b0);
    check_output("failed_lfsr",   32'(dut.u_lfsr.state), 32'(model));
    check_output("failed_valid",  32'(noise_valid), 32'd1);
    check_output("failed_sticky", 32'(health_fail), 32'd1);
    reseed = 1'b1;
    apply_stimulus(1'b1);
    reseed = 1'b0;
    check_output("reseed_lfsr",   32'(dut.u_lfsr.state), 32'hACE1);
    check_output("reseed_health", 32'(health_fail), 32'd0);
    check_output("reseed_valid",  32'(noise_valid), 32'd0);
    check_output("reseed_rep",    32'(dut.rep_cnt), 32'd0);
`ifdef VN_DEBIAS_EN
    check_output("reseed_fsm",    32'(dut.pair_state), 32'(EMPTY));
`endif

    // Backpressure: bit held while not ready, reload after consumption.
    pulse_reset();
    model = 16'hACE1;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1);
      model = model_next(model, 1'b0);
      if (i < 4) apply_stimulus(1'b0);
    end
    check_output("bp_start_bit", 32'(noise_bit), 32'd1);
    noise_ready = 1'b0;
    apply_stimulus(1'b0);
    check_output("bp_idle_valid", 32'(noise_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1);
      model = model_next(model, 1'b0);
      check_output("bp_hold_valid", 32'(noise_valid), 32'd1);
      check_output("bp_hold_bit",   32'(noise_bit),   32'd1);
      check_output("bp_hold_lfsr",  32'(dut.u_lfsr.state), 32'(model));
      apply_stimulus(1'b0);
    end
    noise_ready = 1'b1;
    apply_stimulus(1'b0);
    check_output("bp_drop_valid", 32'(noise_valid), 32'd0);
    apply_stimulus(1'b1);
    check_output("bp_reload_lfsr",  32'(dut.u_lfsr.state), 32'hEB62);
    check_output("bp_reload_valid", 32'(noise_valid), 32'd1);
    check_output("bp_reload_bit",   32'(noise_bit),   32'd0);

    // Asynchronous reset in the middle of a valid transfer.
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1);
      if (i < 4) apply_stimulus(1'b0);
    end
    check_output("pre_rst_valid", 32'(noise_valid), 32'd1);
    check_output("pre_rst_bit",   32'(noise_bit),   32'd1);
    rst = 1'b1;
    #1;
    check_output("async_rst_valid", 32'(noise_valid), 32'd0);
    check_output("async_rst_bit",   32'(noise_bit),   32'd0);
    check_output("async_rst_lfsr",  32'(dut.u_lfsr.state), 32'hACE1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Alternating source: entropy mixed into the LFSR, no health failure.
    model = 16'hACE1;
    have_first = 1'b0;
    first_raw  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raw_noise = i[0];
      apply_stimulus(1'b0);
      apply_stimulus(1'b0);
      apply_stimulus(1'b1);
`ifdef VN_DEBIAS_EN
      if (!have_first) begin
        first_raw  = raw_noise;
        have_first = 1'b1;
        mix        = 1'b0;
      end else begin
        mix        = (first_raw != raw_noise) ? first_raw : 1'b0;
        have_first = 1'b0;
      end
`else
      mix = raw_noise;
`endif
      model = model_next(model, mix);
      if (i == 1) begin
`ifdef VN_DEBIAS_EN
        check_output("alt_step2_lfsr", 32'(dut.u_lfsr.state), 32'h7138);
`else
        check_output("alt_step2_lfsr", 32'(dut.u_lfsr.state), 32'hF138);
`endif
      end
      check_output("alt_lfsr",   32'(dut.u_lfsr.state), 32'(model));
      check_output("alt_bit",    32'(noise_bit), 32'(model[0]));
      check_output("alt_health", 32'(health_fail), 32'd0);
    end

    // Lock-up guard: entropy flip would zero the state, seed reloads.
    pulse_reset();
    g_raw = 1'b1;
    guard_cycle(1'b0);
    guard_cycle(1'b0);
    guard_cycle(1'b1);
`ifdef VN_DEBIAS_EN
    check_output("guard_pre_lfsr", 32'(dut_guard.u_lfsr.state), 32'h6801);
    g_raw = 1'b0;
    guard_cycle(1'b0);
    guard_cycle(1'b0);
    guard_cycle(1'b1);
    check_output("guard_lfsr", 32'(dut_guard.u_lfsr.state), 32'hD002);
    check_output("guard_bit",  32'(g_bit), 32'd0);
`else
    check_output("guard_lfsr", 32'(dut_guard.u_lfsr.state), 32'h6801);
    check_output("guard_bit",  32'(g_bit), 32'd1);
`endif
    check_output("guard_valid", 32'(g_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/noise_conditioner.md
Name: noise_conditioner

Overview:
Upstream entropy stage feeding the Game-of-Life colour generator's `noise` input. Samples a raw asynchronous noise pin on the pixel-clock enable and debiases it. Mixes the result into an LFSR and presents one conditioned bit at a time on a valid/ready handshake. A repetition-count health test flags a stuck noise source.

Parameters:
LFSR_WIDTH, 16, LFSR state width (legal 8..32).
LFSR_TAPS, 16'hB400, Galois feedback mask, LFSR_WIDTH bits.
SEED, 16'hACE1, reset/reseed value; must be non-zero.
REP_LIMIT, 32, consecutive identical raw samples that trip health_fail (legal 2..255).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  sample/advance enable (the clkDiv pixel tick, one cycle high every 2 clocks)
raw_noise  in  1  asynchronous raw noise pin
reseed  in  1  single-cycle pulse (rotary center "down" event)
noise_bit  out  1  conditioned output bit
noise_valid  out  1  noise_bit holds a fresh bit
noise_ready  in  1  consumer accepts noise_bit this cycle
health_fail  out  1  sticky stuck-source flag

Behaviour:
- Reset: sync FFs=0, lfsr=SEED, pair FSM=EMPTY, rep_cnt=0, last_raw=0. Outputs: noise_bit=0, noise_valid=0, health_fail=0.
- Synchronizer: raw_noise → 2 FFs every clk; raw_s is the second FF. It is sampled only when en=1.
- Pair FSM (von Neumann):
  - States EMPTY and HAVE_FIRST.
  - EMPTY, en: store raw_s as first, go to HAVE_FIRST.
  - HAVE_FIRST, en: pair (first, raw_s). 01→debiased bit 0, 10→bit 1, with vn_valid=1 that cycle. 00 or 11 is discarded. Return to EMPTY.
- LFSR, on every en cycle:
  - lfsr_next = (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0).
  - If vn_valid && !health_fail, also XOR vn_bit into lfsr_next[LFSR_WIDTH-1].
  - If lfsr_next==0, load SEED instead (lock-up guard).
- Output register:
  - On an en cycle, if !noise_valid || noise_ready, then noise_bit ← lfsr_next[0] and noise_valid ← 1.
  - Else if noise_ready, then noise_valid ← 0.
  - While valid && !ready, noise_bit is held stable.
  - Latency: raw edge → first possible influence on noise_bit is ≤ 2 (sync) + 4 (two en periods) clocks.
- Health test:
  - On en: rep_cnt ← (raw_s==last_raw) ? sat(rep_cnt+1) : 1, and last_raw ← raw_s.
  - When rep_cnt reaches REP_LIMIT, health_fail ← 1 (sticky).
  - While failed, LFSR runs pure pseudo-random; output continues.
- reseed: the next clock sets lfsr=SEED, FSM=EMPTY, rep_cnt=0, health_fail=0, noise_valid=0. reseed has priority over a simultaneous en.
- Mid-operation async rst: all state returns to reset values immediately.

Optional Feature:
Macro VN_DEBIAS_EN.
- Defined: von Neumann pair FSM as above.
- Undefined: FSM removed; vn_bit=raw_s and vn_valid=en every en cycle (raw mixing, 2× entropy rate, no bias removal).
- Health test and handshake are identical in both builds.

Decomposition:
- Shared package `noise_pkg`: pair-FSM state enum (EMPTY, HAVE_FIRST), default SEED/TAPS constants, rep-counter width function clog2(REP_LIMIT+1).
- One natural sub-module, `noise_lfsr`: Galois shift with entropy XOR-in and zero guard, with ports clk, rst, step, load_seed, mix_bit, mix_valid, state.

Test Plan:
1. Reset then en toggling, raw_noise=0 constant, noise_ready=1 → health_fail rises on the en where rep_cnt hits 32. No vn_valid ever. Output equals the pure LFSR sequence from 0xACE1; first bit = bit0 of 0xACE1's successor.
2. raw_noise alternating 0,1 per en, VN_DEBIAS_EN on → each pair yields vn_bit 0, one every 2 en. Compare the LFSR trace against a reference model with XOR-in; health_fail stays 0.
3. Backpressure: noise_ready=0 for 10 en periods → noise_valid stays 1 and noise_bit stable. Ready=1 for one clock off-en → valid drops; the next en reloads.
4. Force the LFSR to zero via a crafted mix (or a force) → the next state equals SEED 0xACE1, never 0.
5. After health_fail=1, pulse reseed coincident with en → lfsr=0xACE1, health_fail=0, noise_valid=0, FSM EMPTY.
6. Assert rst mid-stream with noise_valid=1 → noise_valid=0 and noise_bit=0 in the same cycle; lfsr=SEED.
